branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor (BTB + saturating counters) for the 5-stage pipeline.
//  IF stage looks up the fetch PC and gets a predicted next PC in the same cycle.
//  MEM stage reports each resolved branch or jump; the block trains its table and flags mispredicts.
//  Replaces fixed predict-not-taken + MEM-stage flush. MODE=0 reproduces that baseline.
// PARAMETERS
//  ENTRIES  64  table depth, power of 2, >=2; INDEX_W=log2(ENTRIES) is a localparam.
//  PC_W     32  PC/target width; TAG_W=PC_W-INDEX_W-2 is a localparam.
//  CTR_W    2   saturating-counter width, >=1.
//  CNT_W    32  performance-counter width.
//  MODE     1   0 = static not-taken (table never predicts taken); 1 = dynamic.
// PORTS
//  clk             in   1      cpu clock
//  rst             in   1      synchronous reset, active-high
//  clear           in   1      request table invalidation sweep
//  IF_pc_i         in   PC_W   fetch PC to look up
//  pred_taken      out  1      lookup predicts taken
//  pred_target     out  PC_W   predicted next PC
//  upd_valid       in   1      MEM stage resolves a branch/jump this cycle
//  upd_pc          in   PC_W   PC of the resolved instruction
//  upd_is_jump     in   1      instruction is jal/jalr (always taken)
//  upd_taken       in   1      actual outcome
//  upd_target      in   PC_W   actual taken target
//  upd_pred_taken  in   1      prediction carried down the pipe with the instruction
//  upd_pred_target in   PC_W   predicted target carried down the pipe
//  mispredict      out  1      pipeline must flush and redirect
//  redirect_pc     out  PC_W   correct next PC when mispredict=1
//  busy            out  1      clear sweep in progress
//  br_cnt          out  CNT_W  resolved branch/jump count
//  miss_cnt        out  CNT_W  mispredict count
// BEHAVIOUR
//  Entry = {valid, tag[TAG_W], target[PC_W], ctr[CTR_W]}. idx=pc[INDEX_W+1:2], tag=pc[PC_W-1:INDEX_W+2].
//  FSM states: IDLE, CLEAR.
//   rst -> CLEAR with sweep_idx=0, even if a sweep is already running (sweep restarts at 0).
//   CLEAR: entry[sweep_idx].valid<=0 each cycle; after ENTRIES cycles -> IDLE. busy=1 in CLEAR.
//   IDLE: clear=1 -> CLEAR with sweep_idx=0. clear is ignored while busy.
//  Lookup (combinational, zero latency): hit = valid & tag match.
//   pred_taken = MODE & ~busy & hit & ctr[CTR_W-1].
//   pred_target = pred_taken ? entry.target : IF_pc_i+4 (mod 2^PC_W).
//  Update (written at the clock edge; only when upd_valid & ~busy & MODE=1):
//   hit: if taken, ctr saturating +1 (max 2^CTR_W-1) and target<=upd_target; else ctr saturating -1 (min 0).
//   hit and jump: ctr<=max, target<=upd_target.
//   miss and taken: allocate/overwrite: valid=1, tag, target; ctr=max if jump, else 2^(CTR_W-1) (weak taken).
//   miss and not taken: no write.
//  Lookup and update to the same idx in one cycle: lookup returns the pre-update entry.
//  mispredict (combinational, evaluated also while busy) =
//   upd_valid & ((upd_pred_taken!=upd_taken) | (upd_taken & upd_pred_target!=upd_target)).
//  redirect_pc = upd_taken ? upd_target : upd_pc+4.
//  br_cnt +1 on upd_valid; miss_cnt +1 on mispredict. Both saturate at all-ones and are counted while busy.
//  Reset values:
//   pred_taken=0, pred_target=IF_pc_i+4, busy=1, br_cnt=0, miss_cnt=0.
//   mispredict and redirect_pc follow their inputs.
//   Table contents are unknown until the sweep completes, and are never used before then.
// TESTING
//  1. Release rst, then wait: busy=1 for exactly 64 cycles, then 0. pred_taken stays 0 throughout.
//  2. Taken branch at 0x100->0x80 (pred 0/0x104): mispredict=1, redirect=0x80.
//     Next lookup of 0x100 gives pred_taken=1, target=0x80.
//  3. Counter training on the same branch:
//     Two not-taken updates: first one ctr 2->1 (pred_taken=0 afterwards).
//     Second one ctr ->0, which saturates at 0.
//     Three taken updates: ctr reaches 3 and saturates.
//  4. Alias check: PCs 0x100 and 0x200 (ENTRIES=64) share an index.
//     Allocate 0x200 and the 0x100 lookup misses; same-cycle update+lookup returns old data.
//  5. Jump 0x40->0x400 (upd_is_jump, pred 0) gives ctr=3.
//     A correct later update with pred 1/0x400 gives mispredict=0.
//     The same update with pred_target 0x404 gives mispredict=1.
//  6. Assert clear mid-run, then rst at sweep cycle 10: sweep restarts and busy lasts 64 cycles.
//     Updates during busy leave the table unchanged but still increment br_cnt.
//     MODE=0 build: pred_taken is never 1.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters.
// Latency: lookup is combinational (same cycle); training is written at the next clk edge.
// Backpressure: none; busy=1 during the invalidation sweep suppresses predictions and training.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (starts an invalidation sweep)
//   clear            request an invalidation sweep (ignored while busy)
//   IF_pc_i          fetch PC; pred_taken / pred_target give the predicted next PC
//   upd_*            resolved branch/jump from MEM, with the prediction it carried
//   mispredict       flush/redirect request; redirect_pc is the correct next PC
//   busy             invalidation sweep in progress
//   br_cnt, miss_cnt saturating resolved-branch and mispredict counters
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32,
  parameter int MODE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [PC_W-1:0]  IF_pc_i,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [PC_W-1:0]  upd_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = PC_W - INDEX_W - 2;
  localparam logic DYN   = (MODE != 0);
  localparam logic [CTR_W-1:0]   CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]   CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;

  // Table storage has no reset: it is only trusted after the sweep has
  // invalidated every entry, and lookups/updates are gated while busy.
  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [CNT_W-1:0]   br_q, miss_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d     = S_CLEAR;
          sweep_idx_d = '0;
        end
      end
      S_CLEAR: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = S_IDLE;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = S_CLEAR;
        sweep_idx_d = '0;
      end
    endcase
  end

  assign busy = (state_q == S_CLEAR);

  // ---------------- Lookup ----------------
  logic [INDEX_W-1:0] l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic               l_hit;

  assign l_idx       = IF_pc_i[INDEX_W+1:2];
  assign l_tag       = IF_pc_i[PC_W-1:INDEX_W+2];
  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = DYN & ~busy & l_hit & ctr_q[l_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[l_idx] : IF_pc_i + PC_W'(4);

  // ---------------- Resolution ----------------
  assign mispredict  = upd_valid &
                       ((upd_pred_taken != upd_taken) |
                        (upd_taken & (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

  // ---------------- Training ----------------
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit, u_en;
  logic               wr_en;
  logic [PC_W-1:0]    wr_target;
  logic [CTR_W-1:0]   wr_ctr;

  assign u_idx = upd_pc[INDEX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:INDEX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_en  = upd_valid & ~busy & DYN;

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[u_idx];
    wr_ctr    = ctr_q[u_idx];
    if (u_en) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_ctr    = CTR_MAX;
          wr_target = upd_target;
        end else if (upd_taken) begin
          wr_target = upd_target;
          if (ctr_q[u_idx] != CTR_MAX) wr_ctr = ctr_q[u_idx] + 1'b1;
        end else begin
          if (ctr_q[u_idx] != '0) wr_ctr = ctr_q[u_idx] - 1'b1;
        end
      end else if (upd_taken || upd_is_jump) begin
        // Miss on a taken instruction replaces whatever lives at this index.
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_ctr    = upd_is_jump ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      ctr_q[u_idx]    <= wr_ctr;
    end
  end

  // ---------------- Performance counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      if (upd_valid && (br_q != {CNT_W{1'b1}}))  br_q   <= br_q + 1'b1;
      if (mispredict && (miss_q != {CNT_W{1'b1}})) miss_q <= miss_q + 1'b1;
    end
  end

  assign br_cnt   = br_q;
  assign miss_cnt = miss_q;

endmodule
